e203_ifu_predec_q: RTL and testbench

Parametrised pre-decode queue between the IFU fetch path and the IFU branch/issue logic. Each accepted instruction (32-bit or RVC) goes through a single-cycle mini-decode: instruction length, branch/jump class, branch immediate, integer register operands, mul/div class, optional FP operand usage and a static branch prediction with target. The result is stored in a DEPTH-entry FIFO and presented to the consumer over a valid/ready handshake. This gives the IFU decoupled fetch-ahead with decode results already available when the consumer reads them.

---
 rtl/e203_ifu_pkg.sv | 78 +++++++
 rtl/e203_ifu_predec_q_if.sv | 46 ++++
 rtl/e203_ifu_predec_core.sv | 115 +++++++++++
 rtl/e203_ifu_predec_q.sv | 114 +++++++++++
 tb/tb_e203_ifu_predec_q.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/e203_ifu_pkg.sv
// Shared IFU pre-decode definitions: opcode constants, RVC funct3 codes,
// out_muldiv bit positions, the packed flag struct and the entry width helper.
// Optional FP decode fields exist only when E203_IFU_PREDEC_FPU_EN is defined.
package e203_ifu_pkg;

    // RV32 major opcodes
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    // FP opcode set
    localparam logic [6:0] OpcLoadFp  = 7'b0000111;
    localparam logic [6:0] OpcStoreFp = 7'b0100111;
    localparam logic [6:0] OpcOpFp    = 7'b1010011;
    localparam logic [6:0] OpcFmadd   = 7'b1000011;
    localparam logic [6:0] OpcFmsub   = 7'b1000111;
    localparam logic [6:0] OpcFnmsub  = 7'b1001011;
    localparam logic [6:0] OpcFnmadd  = 7'b1001111;

    // RVC funct3 codes (quadrant 1 for jumps/branches, quadrant 2 for JR/JALR)
    localparam logic [2:0] RvcF3Jal   = 3'b001;
    localparam logic [2:0] RvcF3J     = 3'b101;
    localparam logic [2:0] RvcF3Beqz  = 3'b110;
    localparam logic [2:0] RvcF3Bnez  = 3'b111;
    localparam logic [2:0] RvcF3Jr    = 3'b100;

    // out_muldiv bit positions
    localparam int unsigned MdMulhsu = 0;
    localparam int unsigned MdMul    = 1;
    localparam int unsigned MdDiv    = 2;
    localparam int unsigned MdRem    = 3;
    localparam int unsigned MdDivu   = 4;
    localparam int unsigned MdRemu   = 5;

    typedef struct packed {
`ifdef E203_IFU_PREDEC_FPU_EN
        logic       fp_en;
        logic       frs3en;
        logic       frs2en;
        logic       frs1en;
`endif
        logic [5:0] muldiv;
        logic       prdt_taken;
        logic       rs2en;
        logic       rs1en;
        logic       bxx;
        logic       jalr;
        logic       jal;
        logic       bjp;
        logic       rv32;
    } predec_flags_t;

    localparam int unsigned FlagsW = $bits(predec_flags_t);

    // Entry layout, LSB first: flags, rs1idx, rs2idx, jalr_rs1idx, imm, pc, tgt
    function automatic int unsigned entry_w(input int unsigned pc_size, input int unsigned xlen,
                                            input int unsigned rfidx_w);
        return FlagsW + 3 * rfidx_w + xlen + 2 * pc_size;
    endfunction

    function automatic logic [5:0] muldiv_onehot(input logic [2:0] funct3);
        logic [5:0] md;
        md = '0;
        case (funct3)
            3'd0, 3'd1, 3'd3: md[MdMul] = 1'b1;
            3'd2:             md[MdMulhsu] = 1'b1;
            3'd4:             md[MdDiv] = 1'b1;
            3'd5:             md[MdDivu] = 1'b1;
            3'd6:             md[MdRem] = 1'b1;
            default:          md[MdRemu] = 1'b1;
        endcase
        return md;
    endfunction

endpackage

// File: rtl/e203_ifu_predec_q_if.sv
// Handshake bundle of the pre-decode queue.
// slave: the queue (accepts in_*, drives out_*); master: fetch side + consumer.
// out_frs1en/out_frs2en/out_frs3en/out_fp_en exist only with E203_IFU_PREDEC_FPU_EN.
interface e203_ifu_predec_q_if #(
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic [PC_SIZE-1:0] in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [PC_SIZE-1:0] out_pc;
    logic               out_rv32, out_bjp, out_jal, out_jalr, out_bxx;
    logic               out_rs1en, out_rs2en;
    logic [RFIDX_W-1:0] out_rs1idx, out_rs2idx, out_jalr_rs1idx;
    logic [XLEN-1:0]    out_bjp_imm;
    logic [5:0]         out_muldiv;
    logic               out_prdt_taken;
    logic [PC_SIZE-1:0] out_prdt_tgt;
`ifdef E203_IFU_PREDEC_FPU_EN
    logic               out_frs1en, out_frs2en, out_frs3en, out_fp_en;
`endif

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rv32, out_bjp, out_jal, out_jalr, out_bxx,
        input  out_rs1en, out_rs2en, out_rs1idx, out_rs2idx, out_jalr_rs1idx, out_bjp_imm,
        input  out_muldiv, out_prdt_taken, out_prdt_tgt
`ifdef E203_IFU_PREDEC_FPU_EN
        , input out_frs1en, out_frs2en, out_frs3en, out_fp_en
`endif
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rv32, out_bjp, out_jal, out_jalr, out_bxx,
        output out_rs1en, out_rs2en, out_rs1idx, out_rs2idx, out_jalr_rs1idx, out_bjp_imm,
        output out_muldiv, out_prdt_taken, out_prdt_tgt
`ifdef E203_IFU_PREDEC_FPU_EN
        , output out_frs1en, out_frs2en, out_frs3en, out_fp_en
`endif
    );
endinterface

// File: rtl/e203_ifu_predec_core.sv
// Combinational mini-decode of one instruction (RV32 or RVC in bits [15:0]).
// Ports: instr in; flags (class, enables, muldiv, static prediction), bjp_imm,
// rs1idx, rs2idx, jalr_rs1idx out. FP decode only with E203_IFU_PREDEC_FPU_EN.
module e203_ifu_predec_core
    import e203_ifu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
) (
    input  logic [31:0]        instr,
    output predec_flags_t      flags,
    output logic [XLEN-1:0]    bjp_imm,
    output logic [RFIDX_W-1:0] rs1idx,
    output logic [RFIDX_W-1:0] rs2idx,
    output logic [RFIDX_W-1:0] jalr_rs1idx
);
    logic [XLEN-1:0] imm_j, imm_i, imm_b, imm_cj, imm_cb;

    assign imm_j  = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_i  = {{(XLEN-11){instr[31]}}, instr[30:20]};
    assign imm_b  = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_cj = {{(XLEN-11){instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                     instr[2], instr[11], instr[5:3], 1'b0};
    assign imm_cb = {{(XLEN-8){instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3],
                     1'b0};

    always_comb begin
        flags       = '0;
        bjp_imm     = '0;
        rs1idx      = '0;
        rs2idx      = '0;
        jalr_rs1idx = '0;
        if (instr[1:0] == 2'b11) begin
            flags.rv32 = 1'b1;
            case (instr[6:0])
                OpcJal: begin
                    flags.jal = 1'b1;
                    bjp_imm   = imm_j;
                end
                OpcJalr: begin
                    flags.jalr  = 1'b1;
                    bjp_imm     = imm_i;
                    jalr_rs1idx = RFIDX_W'(instr[19:15]);
                end
                OpcBranch: begin
                    flags.bxx   = 1'b1;
                    flags.rs1en = 1'b1;
                    flags.rs2en = 1'b1;
                    bjp_imm     = imm_b;
                end
                OpcOp: begin
                    flags.rs1en = 1'b1;
                    flags.rs2en = 1'b1;
                    if (instr[31:25] == 7'b0000001) flags.muldiv = muldiv_onehot(instr[14:12]);
                end
                OpcOpImm, OpcLoad: flags.rs1en = 1'b1;
                OpcStore: begin
                    flags.rs1en = 1'b1;
                    flags.rs2en = 1'b1;
                end
`ifdef E203_IFU_PREDEC_FPU_EN
                OpcLoadFp: begin
                    flags.fp_en = 1'b1;
                    flags.rs1en = 1'b1;
                end
                OpcStoreFp: begin
                    flags.fp_en  = 1'b1;
                    flags.rs1en  = 1'b1;
                    flags.frs2en = 1'b1;
                end
                OpcOpFp: begin
                    flags.fp_en = 1'b1;
                    // FCVT.*.W[U] and FMV.W.X take their source from the integer file
                    if (instr[31:27] == 5'b11010 || instr[31:27] == 5'b11110) begin
                        flags.rs1en = 1'b1;
                    end else begin
                        flags.frs1en = 1'b1;
                    end
                    flags.frs2en = (instr[31:27] inside {5'b00000, 5'b00001, 5'b00010,
                                                         5'b00011, 5'b00100, 5'b00101,
                                                         5'b10100});
                end
                OpcFmadd, OpcFmsub, OpcFnmsub, OpcFnmadd: begin
                    flags.fp_en  = 1'b1;
                    flags.frs1en = 1'b1;
                    flags.frs2en = 1'b1;
                    flags.frs3en = 1'b1;
                end
`endif
                default: ;
            endcase
            if (flags.rs1en) rs1idx = RFIDX_W'(instr[19:15]);
            if (flags.rs2en) rs2idx = RFIDX_W'(instr[24:20]);
        end else if (instr[1:0] == 2'b01) begin
            if (instr[15:13] == RvcF3J || instr[15:13] == RvcF3Jal) begin
                flags.jal = 1'b1;
                bjp_imm   = imm_cj;
            end else if (instr[15:13] == RvcF3Beqz || instr[15:13] == RvcF3Bnez) begin
                flags.bxx   = 1'b1;
                flags.rs1en = 1'b1;
                rs1idx      = RFIDX_W'({2'b01, instr[9:7]});  // x8..x15
                bjp_imm     = imm_cb;
            end
        end else if (instr[1:0] == 2'b10) begin
            // C.JR / C.JALR: rs2 field zero, rs1 nonzero (rs1 = 0 is reserved / C.EBREAK)
            if (instr[15:13] == RvcF3Jr && instr[6:2] == 5'd0 && instr[11:7] != 5'd0) begin
                flags.jalr  = 1'b1;
                jalr_rs1idx = RFIDX_W'(instr[11:7]);
            end
        end
        flags.bjp        = flags.jal | flags.jalr | flags.bxx;
        // backward conditional branches predicted taken
        flags.prdt_taken = flags.jal | flags.jalr | (flags.bxx & bjp_imm[XLEN-1]);
    end
endmodule

// File: rtl/e203_ifu_predec_q.sv
// Pre-decode FIFO between IFU fetch and IFU branch/issue logic.
// Ports: clk, rst (sync, active-high), flush, bus (slave modport: in_* handshake
// with instruction/PC, out_* handshake with registered decode of the head entry),
// count (occupancy). E203_IFU_PREDEC_FPU_EN adds FP operand flags per entry.
module e203_ifu_predec_q
    import e203_ifu_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    e203_ifu_predec_q_if.slave     bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;
    localparam int unsigned OffRs1 = FlagsW;
    localparam int unsigned OffRs2 = OffRs1 + RFIDX_W;
    localparam int unsigned OffJr  = OffRs2 + RFIDX_W;
    localparam int unsigned OffImm = OffJr + RFIDX_W;
    localparam int unsigned OffPc  = OffImm + XLEN;
    localparam int unsigned OffTgt = OffPc + PC_SIZE;
    localparam int unsigned EntryW = entry_w(PC_SIZE, XLEN, RFIDX_W);

    predec_flags_t      dec_flags;
    logic [XLEN-1:0]    dec_imm;
    logic [RFIDX_W-1:0] dec_rs1idx, dec_rs2idx, dec_jr_idx;
    logic [EntryW-1:0]  wr_entry, head;
    predec_flags_t      head_flags;

    logic [EntryW-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]    wptr_q, rptr_q;
    logic [CntW-1:0]    count_q;
    logic               push, pop;

    e203_ifu_predec_core #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W)
    ) u_core (
        .instr       (bus.in_instr),
        .flags       (dec_flags),
        .bjp_imm     (dec_imm),
        .rs1idx      (dec_rs1idx),
        .rs2idx      (dec_rs2idx),
        .jalr_rs1idx (dec_jr_idx)
    );

    assign wr_entry = {bus.in_pc + PC_SIZE'(dec_imm), bus.in_pc, dec_imm,
                       dec_jr_idx, dec_rs2idx, dec_rs1idx, dec_flags};

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.in_ready  = (count_q != CntW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready && !flush;
    assign pop           = bus.out_valid && bus.out_ready;
    assign count         = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            // the flush-cycle pop is already consumed downstream; push is dropped
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wr_entry;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head       = mem_q[rptr_q];
    assign head_flags = predec_flags_t'(head[FlagsW-1:0]);

    assign bus.out_rv32        = head_flags.rv32;
    assign bus.out_bjp         = head_flags.bjp;
    assign bus.out_jal         = head_flags.jal;
    assign bus.out_jalr        = head_flags.jalr;
    assign bus.out_bxx         = head_flags.bxx;
    assign bus.out_rs1en       = head_flags.rs1en;
    assign bus.out_rs2en       = head_flags.rs2en;
    assign bus.out_muldiv      = head_flags.muldiv;
    assign bus.out_prdt_taken  = head_flags.prdt_taken;
    assign bus.out_rs1idx      = head[OffRs1 +: RFIDX_W];
    assign bus.out_rs2idx      = head[OffRs2 +: RFIDX_W];
    assign bus.out_jalr_rs1idx = head[OffJr +: RFIDX_W];
    assign bus.out_bjp_imm     = head[OffImm +: XLEN];
    assign bus.out_pc          = head[OffPc +: PC_SIZE];
    assign bus.out_prdt_tgt    = head[OffTgt +: PC_SIZE];
`ifdef E203_IFU_PREDEC_FPU_EN
    assign bus.out_frs1en      = head_flags.frs1en;
    assign bus.out_frs2en      = head_flags.frs2en;
    assign bus.out_frs3en      = head_flags.frs3en;
    assign bus.out_fp_en       = head_flags.fp_en;
`endif
endmodule

// File: tb/tb_e203_ifu_predec_q.sv
// Bench for e203_ifu_predec_q (default build, DEPTH = 2): directed scenarios
// plus randomized traffic checked against a queue-based reference model.
module tb_e203_ifu_predec_q;
    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] count;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    e203_ifu_predec_q_if #(.PC_SIZE(32), .XLEN(32), .RFIDX_W(5)) bus ();

    e203_ifu_predec_q #(
        .DEPTH   (DEPTH),
        .PC_SIZE (32),
        .XLEN    (32),
        .RFIDX_W (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        rv32, bjp, jal, jalr, bxx, rs1en, rs2en;
        logic [4:0]  rs1idx, rs2idx, jalr_rs1idx;
        logic [31:0] imm;
        logic [5:0]  muldiv;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    function automatic exp_t observed();
        exp_t o;
        o.pc = bus.out_pc;           o.rv32 = bus.out_rv32;     o.bjp = bus.out_bjp;
        o.jal = bus.out_jal;         o.jalr = bus.out_jalr;     o.bxx = bus.out_bxx;
        o.rs1en = bus.out_rs1en;     o.rs2en = bus.out_rs2en;   o.rs1idx = bus.out_rs1idx;
        o.rs2idx = bus.out_rs2idx;   o.jalr_rs1idx = bus.out_jalr_rs1idx;
        o.imm = bus.out_bjp_imm;     o.muldiv = bus.out_muldiv; o.taken = bus.out_prdt_taken;
        o.tgt = bus.out_prdt_tgt;
        return o;
    endfunction

    // Reference decode: offsets assembled arithmetically from the encoding's bit weights.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   imm;
        e = '0;
        imm = 0;
        e.pc = pc;
        if (ins[1:0] == 2'b11) begin
            e.rv32 = 1'b1;
            case (ins[6:0])
                7'h6F: begin
                    e.jal = 1'b1;
                    imm = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                          - int'(ins[31]) * (1 << 20);
                end
                7'h67: begin
                    e.jalr = 1'b1;
                    e.jalr_rs1idx = ins[19:15];
                    imm = int'(ins[30:20]) - int'(ins[31]) * 2048;
                end
                7'h63: begin
                    e.bxx = 1'b1; e.rs1en = 1'b1; e.rs2en = 1'b1;
                    imm = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
                          - int'(ins[31]) * 4096;
                end
                7'h33: begin
                    e.rs1en = 1'b1; e.rs2en = 1'b1;
                    if (ins[31:25] == 7'h01) begin
                        case (ins[14:12])
                            3'd2:    e.muldiv = 6'b000001;
                            3'd4:    e.muldiv = 6'b000100;
                            3'd5:    e.muldiv = 6'b010000;
                            3'd6:    e.muldiv = 6'b001000;
                            3'd7:    e.muldiv = 6'b100000;
                            default: e.muldiv = 6'b000010;
                        endcase
                    end
                end
                7'h13, 7'h03: e.rs1en = 1'b1;
                7'h23: begin e.rs1en = 1'b1; e.rs2en = 1'b1; end
                default: ;
            endcase
            if (e.rs1en) e.rs1idx = ins[19:15];
            if (e.rs2en) e.rs2idx = ins[24:20];
        end else if (ins[1:0] == 2'b01 && (ins[15:13] == 3'b101 || ins[15:13] == 3'b001)) begin
            e.jal = 1'b1;
            imm = int'(ins[5:3]) * 2 + int'(ins[11]) * 16 + int'(ins[2]) * 32 + int'(ins[7]) * 64
                  + int'(ins[6]) * 128 + int'(ins[10:9]) * 256 + int'(ins[8]) * 1024
                  - int'(ins[12]) * 2048;
        end else if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11) begin
            e.bxx = 1'b1; e.rs1en = 1'b1;
            e.rs1idx = 5'(8 + int'(ins[9:7]));
            imm = int'(ins[4:3]) * 2 + int'(ins[11:10]) * 8 + int'(ins[2]) * 32
                  + int'(ins[6:5]) * 64 - int'(ins[12]) * 256;
        end else if (ins[1:0] == 2'b10 && ins[15:13] == 3'b100 && ins[6:2] == 5'd0
                     && ins[11:7] != 5'd0) begin
            e.jalr = 1'b1;
            e.jalr_rs1idx = ins[11:7];
        end
        e.imm   = imm;
        e.bjp   = e.jal | e.jalr | e.bxx;
        e.taken = e.jal | e.jalr | (e.bxx && imm < 0);
        e.tgt   = pc + e.imm;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            0: r[6:0] = 7'h6F;
            1: r[6:0] = 7'h67;
            2: r[6:0] = 7'h63;
            3: begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h01 : 7'h00; end
            4: r[6:0] = 7'h13;
            5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;
            7: begin
                r[1:0] = 2'b01;
                case ($urandom_range(0, 3))
                    0: r[15:13] = 3'b101;
                    1: r[15:13] = 3'b001;
                    2: r[15:13] = 3'b110;
                    default: r[15:13] = 3'b111;
                endcase
            end
            8: begin
                r[1:0] = 2'b10; r[15:13] = 3'b100;
                if ($urandom_range(0, 1) != 0) r[6:2] = 5'd0;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t zero;
        zero = '0;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        step(); step();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || count !== 2'd0) begin
                $display("FAIL reset_ctrl[%0d]: got valid=%b ready=%b count=%0d want 0 1 0",
                         k, bus.out_valid, bus.in_ready, count);
                miscompares++;
            end
            vectors++;
            if (observed() !== zero) begin
                $display("FAIL reset_data[%0d]: got %h want 0", k, observed());
                miscompares++;
            end
            rst = 1'b0;
            step();
        end
    endtask

    task automatic test_jal();
        exp_t e;
        e = '0;
        e.pc = 32'h8000_0000; e.rv32 = 1; e.bjp = 1; e.jal = 1; e.imm = 32'h8;
        e.taken = 1; e.tgt = 32'h8000_0008;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0080_006F; bus.in_pc = 32'h8000_0000;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin
            $display("FAIL jal: got valid=%b %h want valid=1 %h", bus.out_valid, observed(), e);
            miscompares++;
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b0 || count !== 2'd0) begin
            $display("FAIL jal_drain: got valid=%b count=%0d want 0 0", bus.out_valid, count);
            miscompares++;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        e = '0;
        e.pc = 32'h8000_0010; e.rv32 = 1; e.bjp = 1; e.bxx = 1; e.rs1en = 1; e.rs2en = 1;
        e.imm = 32'hFFFF_FFFC; e.taken = 1; e.tgt = 32'h8000_000C;
        bus.in_valid = 1'b1; bus.in_instr = 32'hFE00_0EE3; bus.in_pc = 32'h8000_0010;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin
            $display("FAIL beq: got valid=%b %h want valid=1 %h", bus.out_valid, observed(), e);
            miscompares++;
        end
        step();
    endtask

    task automatic test_mul_cjr();
        exp_t e1, e2;
        e1 = '0;
        e1.pc = 32'h8000_0020; e1.rv32 = 1; e1.rs1en = 1; e1.rs2en = 1; e1.rs1idx = 5'd2;
        e1.rs2idx = 5'd3; e1.muldiv = 6'b000010; e1.tgt = 32'h8000_0020;
        e2 = '0;
        e2.pc = 32'h8000_0024; e2.bjp = 1; e2.jalr = 1; e2.jalr_rs1idx = 5'd1; e2.taken = 1;
        e2.tgt = 32'h8000_0024;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0231_00B3; bus.in_pc = 32'h8000_0020;
        step();
        bus.in_instr = 32'h0000_8082; bus.in_pc = 32'h8000_0024;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (count !== 2'd2 || observed() !== e1) begin
            $display("FAIL mul: got count=%0d %h want count=2 %h", count, observed(), e1);
            miscompares++;
        end
        bus.out_ready = 1'b1;
        step();
        vectors++;
        if (count !== 2'd1 || observed() !== e2) begin
            $display("FAIL c_jr: got count=%0d %h want count=1 %h", count, observed(), e2);
            miscompares++;
        end
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0000_0013;
        bus.in_pc = 32'h100; step();
        bus.in_pc = 32'h104; step();
        vectors++;
        if (count !== 2'd2 || bus.in_ready !== 1'b0) begin
            $display("FAIL full: got count=%0d ready=%b want 2 0", count, bus.in_ready);
            miscompares++;
        end
        bus.in_pc = 32'h108; step();
        vectors++;
        if (count !== 2'd2 || bus.out_pc !== 32'h100) begin
            $display("FAIL full_hold: got count=%0d pc=%h want 2 100", count, bus.out_pc);
            miscompares++;
        end
        bus.out_ready = 1'b1; step();
        bus.out_ready = 1'b0;
        vectors++;
        if (count !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_pc !== 32'h104) begin
            $display("FAIL pop_a: got count=%0d ready=%b pc=%h want 1 1 104",
                     count, bus.in_ready, bus.out_pc);
            miscompares++;
        end
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        vectors++;
        if (count !== 2'd2 || bus.out_pc !== 32'h104) begin
            $display("FAIL push_c: got count=%0d pc=%h want 2 104", count, bus.out_pc);
            miscompares++;
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h108) begin
            $display("FAIL wrap_c: got valid=%b pc=%h want 1 108", bus.out_valid, bus.out_pc);
            miscompares++;
        end
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int held = 2; held >= 1; held--) begin
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1; bus.in_instr = 32'h0000_0013;
            for (int k = 0; k < held; k++) begin
                bus.in_pc = 32'h200 + 32'(4 * k);
                step();
            end
            flush = 1'b1; bus.in_instr = 32'h0080_006F; bus.in_pc = 32'h2F0;
            step();
            flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            vectors++;
            if (count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                $display("FAIL flush[%0d]: got count=%0d valid=%b ready=%b want 0 0 1",
                         held, count, bus.out_valid, bus.in_ready);
                miscompares++;
            end
            step(); step();
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                $display("FAIL flush_drop[%0d]: got valid=%b want 0", held, bus.out_valid);
                miscompares++;
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t zero;
        zero = '0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0080_006F; bus.in_pc = 32'h8000_0000;
        step();
        bus.in_valid = 1'b0; rst = 1'b1;
        step();
        vectors++;
        if (count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
            || observed() !== zero) begin
            $display("FAIL mid_reset: got count=%0d valid=%b ready=%b data=%h want 0 0 1 0",
                     count, bus.out_valid, bus.in_ready, observed());
            miscompares++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_random(input int n);
        exp_t q[$];
        exp_t got;
        logic do_push, do_pop;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            vectors++;
            if (count !== q.size() || bus.out_valid !== (q.size() != 0)
                || bus.in_ready !== (q.size() < DEPTH)) begin
                $display("FAIL rand_ctrl@%0d: got count=%0d valid=%b ready=%b want count=%0d",
                         c, count, bus.out_valid, bus.in_ready, q.size());
                miscompares++;
            end
            if (q.size() != 0) begin
                got = observed();
                vectors++;
                if (got !== q[0]) begin
                    $display("FAIL rand_head@%0d: got %h want %h", c, got, q[0]);
                    miscompares++;
                end
            end
            flush         = ($urandom_range(0, 31) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_instr  = rand_instr();
            bus.in_pc     = {$urandom()} & 32'hFFFF_FFFE;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            do_pop  = (q.size() != 0) && bus.out_ready;
            do_push = bus.in_valid && (q.size() < DEPTH) && !flush;
            if (do_pop) void'(q.pop_front());
            if (flush) q.delete();
            else if (do_push) q.push_back(ref_decode(bus.in_instr, bus.in_pc));
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_jal();
        test_branch();
        test_mul_cjr();
        test_full_wrap();
        test_flush();
        test_mid_reset();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
